// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder_arbiter block.
//   state_t : FSM encoding (IDLE, EXEC, RESP)
//   N_DEF   : default number of requesters
//   W_DEF   : default operand/result width
package adder_arbiter_pkg;

  localparam int unsigned N_DEF = 4;
  localparam int unsigned W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/adder.sv
// Team 8-bit combinational adder; carry out is discarded (result mod 2^8).
//   a, b : operands
//   y    : a + b, low 8 bits
module adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  assign y = a + b;

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter in front of one shared adder. One transaction in
// flight: IDLE (arbitrate, latch operands) -> EXEC (add) -> RESP (result).
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester request, held until its gnt is seen
//   op_a, op_b : packed operands, slice i = [i*W +: W]
//   gnt        : one-hot grant pulse (registered)
//   rsp_valid  : one-hot result-valid pulse (registered)
//   sum        : result, holds its value outside RESP
//   busy       : high whenever the FSM is not IDLE
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned W = W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] op_a,
  input  logic [N*W-1:0] op_b,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   sum,
  output logic           busy
);

  localparam int unsigned IW = $clog2(N);

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] id;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  add_y;
  logic          pick_hit;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] ptr_next;

  // Returns {hit, index}: first set request scanning ptr, ptr+1, ... mod N.
  function automatic logic [IW:0] rr_pick(input logic [N-1:0] r,
                                          input logic [IW-1:0] p);
    logic [IW:0] res;
    res = '0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned j;
      j = (32'(p) + k) % N;
      if (!res[IW] && r[j]) res = {1'b1, j[IW-1:0]};
    end
    return res;
  endfunction

  assign {pick_hit, pick_idx} = rr_pick(req, ptr);
  assign ptr_next = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
  assign busy     = (state != IDLE);

  if (W == 8) begin : g_adder
    adder u_adder (
      .a (a_q),
      .b (b_q),
      .y (add_y)
    );
  end else begin : g_add
    assign add_y = a_q + b_q;
  end

  // rsp_valid is loaded on the EXEC edge so it is high during RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      id        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      sum       <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (pick_hit) begin
            a_q           <= op_a[pick_idx*W +: W];
            b_q           <= op_b[pick_idx*W +: W];
            id            <= pick_idx;
            ptr           <= ptr_next;
            gnt[pick_idx] <= 1'b1;
            state         <= EXEC;
          end
        end
        EXEC: begin
          sum           <= add_y;
          rsp_valid[id] <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter (N=4, W=8) with a response scoreboard.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  gnt;
  logic [3:0]  rsp_valid;
  logic [7:0]  sum;
  logic        busy;

  typedef struct {
    int unsigned id;
    logic [7:0]  s;
  } exp_t;

  exp_t        sb[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc   = 0;

  adder_arbiter #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .sum       (sum),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    op_a[i*8 +: 8] = a;
    op_b[i*8 +: 8] = b;
  endtask

  task automatic push(input int unsigned id, input logic [7:0] s);
    exp_t e;
    e.id = id;
    e.s  = s;
    sb.push_back(e);
  endtask

  // Advance one cycle, sample 1 time unit after the edge, check invariants
  // and compare any response against the head of the scoreboard.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    chk("rsp_onehot", 32'($countones(rsp_valid) <= 1), 32'd1);
    chk("gnt_rsp_excl", 32'((gnt != 4'd0) && (rsp_valid != 4'd0)), 32'd0);
    if (rsp_valid !== 4'd0) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_valid), 32'd1 << e.id);
        chk("rsp_sum", 32'(sum), 32'(e.s));
      end
    end
  endtask

  task automatic wait_gnt(input string tag, input logic [3:0] exp, output int unsigned at);
    int unsigned n;
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt === 4'd0 && n < 6);
    chk(tag, 32'(gnt), 32'(exp));
    at = cyc;
  endtask

  initial begin
    int unsigned at;
    int unsigned prev;
    logic [3:0]  order [5];

    rst_n = 1'b0;
    req   = '0;
    op_a  = '0;
    op_b  = '0;
    #3;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single request, latency and busy window
    req = 4'b0001;
    set_op(0, 8'h12, 8'h34);
    push(0, 8'h46);
    tick();
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_busy1", 32'(busy), 32'd1);
    req = '0;
    tick();
    chk("single_rsp", 32'(rsp_valid), 32'h1);
    chk("single_busy2", 32'(busy), 32'd1);
    chk("single_gnt_low", 32'(gnt), 32'd0);
    tick();
    chk("single_idle", 32'(busy), 32'd0);

    // Overflow; sum holds after RESP
    req = 4'b0001;
    set_op(0, 8'hF0, 8'h20);
    push(0, 8'h10);
    wait_gnt("ovf_gnt", 4'b0001, at);
    req = '0;
    tick();
    tick();
    chk("sum_hold1", 32'(sum), 32'h10);
    tick();
    chk("sum_hold2", 32'(sum), 32'h10);

    // All four requesting from reset: order 0,1,2,3,0, 3 cycles apart
    rst_n = 1'b0;
    req   = 4'b1111;
    for (int i = 0; i < 4; i++) set_op(i, 8'(i + 1), 8'(i + 1));
    #1;
    chk("rst2_sum", 32'(sum), 32'd0);
    tick();
    rst_n = 1'b1;
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < 5; k++) push(k % 4, 8'(2 * ((k % 4) + 1)));
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt("rr_gnt", order[k], at);
      if (k > 0) chk("rr_spacing", at - prev, 32'd3);
      prev = at;
    end
    req = '0;
    tick();
    tick();

    // Fairness: grant 2 (ptr -> 3), then 1001 grants 3 before 0
    req = 4'b0100;
    set_op(2, 8'h05, 8'h06);
    push(2, 8'h0B);
    wait_gnt("fair_pre", 4'b0100, at);
    req = '0;
    tick();
    tick();
    req = 4'b1001;
    set_op(3, 8'h07, 8'h08);
    set_op(0, 8'h01, 8'h01);
    push(3, 8'h0F);
    push(0, 8'h02);
    wait_gnt("fair_first", 4'b1000, at);
    req = 4'b0001;
    wait_gnt("fair_second", 4'b0001, at);
    req = '0;
    tick();
    tick();

    // Operand and request changes during EXEC do not affect the result
    req = 4'b0010;
    set_op(1, 8'h20, 8'h03);
    push(1, 8'h23);
    wait_gnt("opchg_gnt", 4'b0010, at);
    set_op(1, 8'hFF, 8'hFF);
    req = '0;
    tick();
    tick();

    // Reset during EXEC: no response, outputs cleared, ptr back to 0
    req = 4'b0001;
    set_op(0, 8'h03, 8'h04);
    wait_gnt("abort_gnt", 4'b0001, at);
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("abort_gnt0", 32'(gnt), 32'd0);
    chk("abort_rsp0", 32'(rsp_valid), 32'd0);
    chk("abort_sum0", 32'(sum), 32'd0);
    chk("abort_busy0", 32'(busy), 32'd0);
    tick();
    tick();
    chk("abort_norsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    req   = 4'b0100;
    set_op(2, 8'h09, 8'h09);
    push(2, 8'h12);
    wait_gnt("post_rst_gnt", 4'b0100, at);
    req = '0;
    tick();
    tick();
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters (2..8).
REQ-002 Parameter W, default 8, operand/result width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  N  per-requester request; bit i held high until gnt[i] seen.
REQ-006 op_a  input  N*W  packed operand A; slice i = bits [i*W +: W].
REQ-007 op_b  input  N*W  packed operand B; same slicing as op_a.
REQ-008 gnt  output  N  one-hot grant, one-cycle pulse, registered.
REQ-009 rsp_valid  output  N  one-hot result-valid, one-cycle pulse, registered.
REQ-010 sum  output  W  result; meaningful only while rsp_valid nonzero.
REQ-011 busy  output  1  high whenever state != IDLE.

Function
REQ-012 One shared W-bit adder; at most one transaction in flight.
REQ-013 FSM states: IDLE, EXEC, RESP.
REQ-014 IDLE: req sampled each cycle; if req == 0, stay IDLE with gnt = rsp_valid = 0.
REQ-015 IDLE with req != 0: winner i chosen round-robin, op_a/op_b slice i latched, id latched, gnt[i] = 1 for the next cycle, next state EXEC.
REQ-016 Round-robin: search order ptr, ptr+1, ..., ptr+N-1 (mod N); first set req bit wins.
REQ-017 ptr updated to (i+1) mod N on each grant; unchanged otherwise; wrap from N-1 to 0.
REQ-018 EXEC (gnt[i] high this cycle): sum register <= latched A + latched B, modulo 2^W (carry discarded), next state RESP.
REQ-019 RESP: rsp_valid[i] = 1 and sum valid for exactly this cycle, next state IDLE.
REQ-020 Latency: req[i] sampled high in IDLE at cycle T -> gnt[i] in T+1 -> rsp_valid[i] in T+2; throughput one transaction per 3 cycles.
REQ-021 req, op_a, op_b ignored in EXEC and RESP; changes there do not affect the in-flight result.
REQ-022 Requester still holding req after its rsp_valid is treated as a new request at the next IDLE sample.
REQ-023 Simultaneous requests: exactly one granted per IDLE cycle; losers remain pending, none dropped.
REQ-024 gnt and rsp_valid never have more than one bit set; never both nonzero in the same cycle.
REQ-025 sum holds its last value outside RESP.

Reset
REQ-026 rst_n low at any time, including mid-transaction: state = IDLE, ptr = 0, gnt = 0, rsp_valid = 0, sum = 0, busy = 0, latched operands/id = 0.
REQ-027 In-flight transaction aborted by reset produces no rsp_valid; requester must re-request.
REQ-028 First IDLE sample occurs on the first rising edge after rst_n deasserts.

Structure
REQ-029 Shared package holds FSM state enum (IDLE, EXEC, RESP) and default constants N_DEF = 4, W_DEF = 8.
REQ-030 Addition performed by one instance of the team's 8-bit combinational adder module adder when W = 8; arbiter logic stays in adder_arbiter.
REQ-031 Round-robin selection is a combinational function inside adder_arbiter; no further sub-modules.

Verification
REQ-032 Single request: req = 0001, A0 = 8'h12, B0 = 8'h34 -> gnt = 0001 at T+1, rsp_valid = 0001 with sum = 8'h46 at T+2, busy high T+1..T+2.
REQ-033 Overflow: A = 8'hF0, B = 8'h20 -> sum = 8'h10.
REQ-034 All four requesting continuously from reset, each A = B = i+1 -> grant order 0,1,2,3,0 with sums 2,4,6,8,2, grants 3 cycles apart.
REQ-035 Fairness: ptr = 3 after granting 2, req = 1001 -> requester 3 granted first, then 0.
REQ-036 Operand change: op_a slice modified during EXEC -> sum reflects value latched in IDLE.
REQ-037 Reset during EXEC -> no rsp_valid, all outputs 0; after release, req = 0100 -> gnt = 0100 (ptr restarted at 0).
